// File: rtl/sram_slot_arbiter.sv
// rtl/sram_slot_arbiter.sv - shares one 8-bit SRAM port between video, CPU and DMA in two-cycle time slots
module sram_slot_arbiter #(
    parameter int ADDR_W = 21
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk35en,
    input  logic [1:0]        i_turbo_option,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [7:0]        i_cpu_wdata,
    output logic              o_cpu_ack,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [7:0]        i_dma_wdata,
    output logic              o_dma_ack,
    output logic [7:0]        o_mem_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [7:0]        o_sram_dq_o,
    output logic              o_sram_dq_oe,
    input  logic [7:0]        i_sram_dq_i,
    output logic              o_sram_we_n
);

    typedef enum logic [1:0] {
        SRC_VID  = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_DMA  = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    logic [2:0]        r_ph;
    logic              r_busy;
    src_e              r_own;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic              r_vid_ack;
    logic              r_cpu_ack;
    logic              r_dma_ack;

    logic [2:0]        w_ph;
    logic [1:0]        w_win;
    logic              w_first;
    logic              w_ev;
    logic              w_ec;
    logic              w_ed;
    src_e              w_sel;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_g_addr;
    logic              w_g_we;
    logic [7:0]        w_g_wdata;

    // clk35en is phase 0 by definition, so it also truncates whatever window was running
    assign w_ph    = i_clk35en ? 3'd0 : r_ph;
    assign w_win   = w_ph[2:1];
    assign w_first = ~w_ph[0] & ~i_rst;

    // a requester being acked right now is still holding its old request
    assign w_ev = i_vid_req & ~r_vid_ack;
    assign w_ec = i_cpu_req & ~r_cpu_ack;
    assign w_ed = i_dma_req & ~r_dma_ack;

    always_comb begin
        w_sel = SRC_NONE;
        if (w_first) begin
            if (i_turbo_option == 2'b11 && w_win != 2'd0) begin
                if (w_ec)      w_sel = SRC_CPU;
                else if (w_ed) w_sel = SRC_DMA;
                else if (w_ev) w_sel = SRC_VID;
            end else if (!w_win[0]) begin
                if (w_ev)      w_sel = SRC_VID;
                else if (w_ec) w_sel = SRC_CPU;
                else if (w_ed) w_sel = SRC_DMA;
            end else begin
                if (w_ec)      w_sel = SRC_CPU;
                else if (w_ev) w_sel = SRC_VID;
                else if (w_ed) w_sel = SRC_DMA;
            end
        end
    end

    assign w_gnt = (w_sel != SRC_NONE);

    always_comb begin
        w_g_addr  = r_addr;
        w_g_we    = 1'b0;
        w_g_wdata = r_wdata;
        case (w_sel)
            SRC_VID: w_g_addr = i_vid_addr;
            SRC_CPU: begin
                w_g_addr  = i_cpu_addr;
                w_g_we    = i_cpu_we;
                w_g_wdata = i_cpu_wdata;
            end
            SRC_DMA: begin
                w_g_addr  = i_dma_addr;
                w_g_we    = i_dma_we;
                w_g_wdata = i_dma_wdata;
            end
            default: ;
        endcase
    end

    // first window cycle is driven straight from the grant, second from the latched copy
    assign o_sram_addr  = w_g_addr;
    assign o_sram_dq_o  = w_g_wdata;
    assign o_sram_dq_oe = w_first ? (w_gnt & w_g_we) : (r_busy & r_we);
    assign o_sram_we_n  = ~(w_gnt & w_g_we);
    assign o_mem_rdata  = r_rdata;
    assign o_vid_ack    = r_vid_ack;
    assign o_cpu_ack    = r_cpu_ack;
    assign o_dma_ack    = r_dma_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ph      <= 3'd0;
            r_busy    <= 1'b0;
            r_own     <= SRC_NONE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 8'd0;
            r_rdata   <= 8'd0;
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
        end else begin
            r_ph      <= w_ph + 3'd1;
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            if (w_first) begin
                // a busy slot reaching a window start here was truncated: drop it unacked
                r_busy <= w_gnt;
                if (w_gnt) begin
                    r_own   <= w_sel;
                    r_we    <= w_g_we;
                    r_addr  <= w_g_addr;
                    r_wdata <= w_g_wdata;
                end
            end else if (r_busy) begin
                r_busy <= 1'b0;
                if (!r_we) r_rdata <= i_sram_dq_i;
                case (r_own)
                    SRC_VID: r_vid_ack <= 1'b1;
                    SRC_CPU: r_cpu_ack <= 1'b1;
                    SRC_DMA: r_dma_ack <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// tb/tb_sram_slot_arbiter.sv - self-checking bench for sram_slot_arbiter
module tb_sram_slot_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk35en = 1'b0;
    logic [1:0]  turbo = 2'b00;
    logic [7:0]  dq_i = 8'd0;
    logic        req [3] = '{1'b0, 1'b0, 1'b0};
    logic        we  [3] = '{1'b0, 1'b0, 1'b0};
    logic [20:0] addr[3] = '{21'd0, 21'd0, 21'd0};
    logic [7:0]  wd  [3] = '{8'd0, 8'd0, 8'd0};

    wire        vid_ack, cpu_ack, dma_ack, sram_dq_oe, sram_we_n;
    wire [7:0]  mem_rdata, sram_dq_o;
    wire [20:0] sram_addr;
    wire [41:0] obs = {vid_ack, cpu_ack, dma_ack, mem_rdata, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n};

    int checks = 0;
    int errors = 0;

    // reference model: requester index 0=video, 1=CPU, 2=DMA; m_own=-1 means no access in flight
    int          m_ph = 0;
    int          m_own = -1;
    logic        m_we = 1'b0;
    logic [20:0] m_addr = 21'd0;
    logic [7:0]  m_wd = 8'd0;
    logic [7:0]  m_rdata = 8'd0;
    logic [2:0]  m_ack = 3'b000;
    bit          inject = 1'b0;
    int          eff;
    bit          start;
    int          e_cand;
    logic [20:0] e_addr;
    logic [7:0]  e_dq;
    logic        e_we, e_oe, e_wen;
    logic [41:0] e_vec;
    logic [2:0]  prev_ack = 3'b000;

    always #5 clk = ~clk;

    sram_slot_arbiter #(.ADDR_W(21)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk35en(clk35en), .i_turbo_option(turbo),
        .i_vid_req(req[0]), .i_vid_addr(addr[0]), .o_vid_ack(vid_ack),
        .i_cpu_req(req[1]), .i_cpu_we(we[1]), .i_cpu_addr(addr[1]), .i_cpu_wdata(wd[1]), .o_cpu_ack(cpu_ack),
        .i_dma_req(req[2]), .i_dma_we(we[2]), .i_dma_addr(addr[2]), .i_dma_wdata(wd[2]), .o_dma_ack(dma_ack),
        .o_mem_rdata(mem_rdata), .o_sram_addr(sram_addr), .o_sram_dq_o(sram_dq_o),
        .o_sram_dq_oe(sram_dq_oe), .i_sram_dq_i(dq_i), .o_sram_we_n(sram_we_n)
    );

    function automatic int choose(input logic [2:0] elig, input int win, input bit t28);
        int ord[3];
        if (t28 && win != 0)  ord = '{1, 2, 0};
        else if (win % 2 == 0) ord = '{0, 1, 2};
        else                   ord = '{1, 0, 2};
        for (int k = 0; k < 3; k++) if (elig[ord[k]]) return ord[k];
        return -1;
    endfunction

    task automatic sample_point();
        logic [2:0] elig;
        clk35en = (m_ph == 0) || inject;
        @(negedge clk);
        eff   = clk35en ? 0 : m_ph;
        start = (eff % 2 == 0) && !rst;
        for (int i = 0; i < 3; i++) elig[i] = req[i] && !m_ack[i];
        e_cand = start ? choose(elig, eff / 2, turbo == 2'b11) : -1;
        if (e_cand >= 0) begin
            e_addr = addr[e_cand];
            e_dq   = (e_cand == 0) ? m_wd : wd[e_cand];
            e_we   = (e_cand != 0) && we[e_cand];
            e_oe   = e_we;
            e_wen  = !e_we;
        end else begin
            e_addr = m_addr;
            e_dq   = m_wd;
            e_we   = 1'b0;
            e_wen  = 1'b1;
            e_oe   = (m_own >= 0 && !start) ? m_we : 1'b0;
        end
        e_vec = {m_ack[0], m_ack[1], m_ack[2], m_rdata, e_addr, e_dq, e_oe, e_wen};
    endtask

    task automatic advance();
        prev_ack = m_ack;
        @(posedge clk);
        if (rst) begin
            m_ph = 0; m_own = -1; m_we = 1'b0; m_addr = 21'd0;
            m_wd = 8'd0; m_rdata = 8'd0; m_ack = 3'b000;
        end else begin
            m_ack = 3'b000;
            if (!start && m_own >= 0) begin
                m_ack[m_own] = 1'b1;
                if (!m_we) m_rdata = dq_i;
                m_own = -1;
            end
            if (start) begin
                m_own = e_cand;
                if (e_cand >= 0) begin
                    m_we = e_we; m_addr = e_addr; m_wd = e_dq;
                end
            end
            m_ph = (eff + 1) % 8;
        end
        #1;
    endtask

    task automatic align_to(input int ph);
        for (int n = 0; n < 8 && m_ph != ph; n++) begin
            sample_point();
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_point(); advance();
        sample_point(); advance();
        rst = 1'b0;
        for (int n = 0; n < 32; n++) begin
            sample_point();
            checks++;
            if ({vid_ack, cpu_ack, dma_ack, sram_dq_oe, sram_we_n, sram_addr} !== {3'b000, 1'b0, 1'b1, 21'd0}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got acks=%b oe=%b we_n=%b addr=%h want 000/0/1/0",
                         n, {vid_ack, cpu_ack, dma_ack}, sram_dq_oe, sram_we_n, sram_addr);
            end
            advance();
        end
    endtask

    task automatic test_vid_cpu_read();
        turbo = 2'b00;
        align_to(0);
        req[0] = 1'b1; addr[0] = 21'h012345;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 21'h004000; wd[1] = 8'h11;
        sample_point();
        checks++;
        if ({sram_addr, sram_dq_oe, sram_we_n} !== {21'h012345, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL vid_grant_w0 got addr=%h oe=%b we_n=%b want 012345/0/1", sram_addr, sram_dq_oe, sram_we_n);
        end
        advance();
        sample_point(); advance();
        sample_point();
        checks++;
        if ({vid_ack, sram_addr} !== {1'b1, 21'h004000}) begin
            errors++;
            $display("FAIL cpu_grant_w1 got vid_ack=%b addr=%h want 1/004000", vid_ack, sram_addr);
        end
        advance();
        req[0] = 1'b0;
        dq_i = 8'h3C;
        sample_point(); advance();
        dq_i = 8'h00;
        sample_point();
        checks++;
        if ({cpu_ack, vid_ack, mem_rdata} !== {1'b1, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL cpu_read_ack got cpu_ack=%b vid_ack=%b rdata=%h want 1/0/3c", cpu_ack, vid_ack, mem_rdata);
        end
        advance();
        req[1] = 1'b0;
    endtask

    task automatic test_cpu_write();
        align_to(1);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 21'h1FFFFF; wd[1] = 8'hA5;
        sample_point();
        checks++;
        if ({sram_we_n, sram_dq_oe} !== 2'b10) begin
            errors++;
            $display("FAIL write_no_w0 got we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe);
        end
        advance();
        sample_point();
        checks++;
        if ({sram_we_n, sram_dq_oe, sram_dq_o, sram_addr} !== {1'b0, 1'b1, 8'hA5, 21'h1FFFFF}) begin
            errors++;
            $display("FAIL write_strobe got we_n=%b oe=%b dq=%h addr=%h want 0/1/a5/1fffff",
                     sram_we_n, sram_dq_oe, sram_dq_o, sram_addr);
        end
        advance();
        sample_point();
        checks++;
        if ({sram_we_n, sram_dq_oe, sram_dq_o} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL write_hold got we_n=%b oe=%b dq=%h want 1/1/a5", sram_we_n, sram_dq_oe, sram_dq_o);
        end
        advance();
        sample_point();
        checks++;
        if ({cpu_ack, mem_rdata} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL write_ack got cpu_ack=%b rdata=%h want 1/3c", cpu_ack, mem_rdata);
        end
        advance();
        req[1] = 1'b0;
    endtask

    task automatic test_turbo28();
        int n_cpu = 0;
        bit seen;
        turbo = 2'b11;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 21'h00C0DE;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 21'h1D0A0;
        for (int n = 0; n < 24; n++) begin
            dq_i = 8'($urandom);
            sample_point();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL turbo28_held cycle %0d got %h want %h", n, obs, e_vec);
            end
            if (cpu_ack) n_cpu++;
            advance();
        end
        checks++;
        if (n_cpu < 4) begin
            errors++;
            $display("FAIL turbo28_cpu_count got %0d want at least 4", n_cpu);
        end
        seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            sample_point();
            seen = cpu_ack;
            advance();
        end
        req[1] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            sample_point();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL turbo28_dma cycle %0d got %h want %h", n, obs, e_vec);
            end
            seen = dma_ack;
            advance();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL turbo28_dma_timeout got no dma_ack want dma_ack");
        end
        req[2] = 1'b0;
        turbo = 2'b00;
    endtask

    task automatic test_inject();
        align_to(1);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 21'h000ABC; wd[1] = 8'h5A;
        sample_point(); advance();
        sample_point();
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL inject_first_strobe got we_n=%b want 0", sram_we_n);
        end
        advance();
        inject = 1'b1;
        sample_point();
        checks++;
        if (obs !== e_vec) begin
            errors++;
            $display("FAIL inject_cycle got %h want %h", obs, e_vec);
        end
        advance();
        inject = 1'b0;
        sample_point();
        checks++;
        if ({sram_we_n, cpu_ack} !== 2'b10) begin
            errors++;
            $display("FAIL inject_abort got we_n=%b cpu_ack=%b want 1/0", sram_we_n, cpu_ack);
        end
        advance();
        sample_point();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL inject_reissue_ack got cpu_ack=%b want 1", cpu_ack);
        end
        advance();
        req[1] = 1'b0;
    endtask

    task automatic test_rst_dma();
        align_to(0);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 21'h1ABCD;
        sample_point();
        checks++;
        if (sram_addr !== 21'h1ABCD) begin
            errors++;
            $display("FAIL rst_dma_grant got addr=%h want 1abcd", sram_addr);
        end
        advance();
        rst = 1'b1;
        sample_point(); advance();
        sample_point();
        checks++;
        if (obs !== {3'b000, 8'h00, 21'd0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_outputs got %h want all reset values", obs);
        end
        advance();
        rst = 1'b0;
        sample_point();
        checks++;
        if ({sram_addr, sram_dq_oe, sram_we_n} !== {21'h1ABCD, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_dma_regrant got addr=%h oe=%b we_n=%b want 1abcd/0/1", sram_addr, sram_dq_oe, sram_we_n);
        end
        advance();
        dq_i = 8'h77;
        sample_point(); advance();
        dq_i = 8'h00;
        sample_point();
        checks++;
        if ({dma_ack, mem_rdata} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL rst_dma_ack got dma_ack=%b rdata=%h want 1/77", dma_ack, mem_rdata);
        end
        advance();
        req[2] = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && prev_ack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else begin
                        we[i] = (i == 0) ? 1'b0 : 1'($urandom);
                        addr[i] = 21'($urandom);
                        wd[i] = 8'($urandom);
                    end
                end else if (req[i] && m_own != i && $urandom_range(31, 0) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    we[i] = (i == 0) ? 1'b0 : 1'($urandom);
                    addr[i] = 21'($urandom);
                    wd[i] = 8'($urandom);
                end
            end
            if ($urandom_range(15, 0) == 0) turbo = 2'($urandom);
            inject = ($urandom_range(63, 0) == 0);
            dq_i = 8'($urandom);
            sample_point();
            checks++;
            if (obs !== e_vec) begin
                errors++;
                $display("FAIL random cycle %0d got %h want %h", n, obs, e_vec);
            end
            advance();
        end
        inject = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vid_cpu_read();
        test_cpu_write();
        test_turbo28();
        test_inject();
        test_rst_dma();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
